// File: rtl/fwrisc_trace_serializer_pkg.sv
// Shared trace types: event mask bit indices, FIFO entry layout and serializer states.
// The tracer bench imports this package as well.
package fwrisc_trace_pkg;

   localparam int EV_INSTR = 0;
   localparam int EV_REG   = 1;
   localparam int EV_MEM   = 2;

   localparam int EV_W   = 3;
   localparam int XLEN   = 32;
   localparam int RA_W   = 6;
   localparam int STRB_W = 4;

   localparam int TRACE_ENTRY_W = 3+32+32+6+32+6+32+6+32+32+32+4;

   // Field order (MSB first) fixes the entry bit offsets.
   typedef struct packed {
      logic [EV_W-1:0]   mask;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   instr;
      logic [RA_W-1:0]   ra_raddr;
      logic [XLEN-1:0]   ra_rdata;
      logic [RA_W-1:0]   rb_raddr;
      logic [XLEN-1:0]   rb_rdata;
      logic [RA_W-1:0]   rd_waddr;
      logic [XLEN-1:0]   rd_wdata;
      logic [XLEN-1:0]   maddr;
      logic [XLEN-1:0]   mdata;
      logic [STRB_W-1:0] mstrb;
   } trace_entry_t;

   typedef enum logic {S_IDLE, S_EMIT} ser_state_e;

endpackage

// File: rtl/fwrisc_trace_serializer_if.sv
// One set of fwrisc trace taps; used both for the core-side capture and the BFM-side output.
interface fwrisc_trace_serializer_if;
   import fwrisc_trace_pkg::*;

   logic [XLEN-1:0]   pc;
   logic [XLEN-1:0]   instr;
   logic              ivalid;
   logic [RA_W-1:0]   ra_raddr;
   logic [XLEN-1:0]   ra_rdata;
   logic [RA_W-1:0]   rb_raddr;
   logic [XLEN-1:0]   rb_rdata;
   logic [RA_W-1:0]   rd_waddr;
   logic [XLEN-1:0]   rd_wdata;
   logic              rd_write;
   logic [XLEN-1:0]   maddr;
   logic [XLEN-1:0]   mdata;
   logic [STRB_W-1:0] mstrb;
   logic              mwrite;
   logic              mvalid;

   modport master (output pc, instr, ivalid, ra_raddr, ra_rdata, rb_raddr, rb_rdata,
                   rd_waddr, rd_wdata, rd_write, maddr, mdata, mstrb, mwrite, mvalid);
   modport slave  (input  pc, instr, ivalid, ra_raddr, ra_rdata, rb_raddr, rb_rdata,
                   rd_waddr, rd_wdata, rd_write, maddr, mdata, mstrb, mwrite, mvalid);

endinterface

// File: rtl/fwrisc_trace_fifo.sv
// Generic single-clock FIFO with a combinational head; pointers carry one extra wrap bit.
module fwrisc_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             do_push, do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop frees the slot this same edge, so a push into a full FIFO is still taken.
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/fwrisc_trace_serializer.sv
// Captures retire/reg/mem trace events per cycle, queues them, and replays
// at most one event strobe per clock in instr, reg, mem order.
module fwrisc_trace_serializer
   import fwrisc_trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   fwrisc_trace_serializer_if.slave   cap_i,
   fwrisc_trace_serializer_if.master  bfm_o,
   input  logic                       clr_ovf,
   output logic                       ovf,
   output logic [CNT_W-1:0]           drop_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   trace_entry_t cap_d, head, cur_q, out_q;
   ser_state_e   state_q;
   logic [EV_W-1:0] emit_d, rest_d;
   logic         push, pop, full, empty, drop;
   logic         mwrite_q, ovf_q;
   logic [CNT_W-1:0] cnt_q;

   assign cap_d = '{mask:     {cap_i.mvalid & cap_i.mwrite, cap_i.rd_write, cap_i.ivalid},
                    pc:       cap_i.pc,       instr:    cap_i.instr,
                    ra_raddr: cap_i.ra_raddr, ra_rdata: cap_i.ra_rdata,
                    rb_raddr: cap_i.rb_raddr, rb_rdata: cap_i.rb_rdata,
                    rd_waddr: cap_i.rd_waddr, rd_wdata: cap_i.rd_wdata,
                    maddr:    cap_i.maddr,    mdata:    cap_i.mdata,
                    mstrb:    cap_i.mstrb};

   assign push = (cap_d.mask != '0);
   assign drop = push && full && !pop;

   fwrisc_trace_fifo #(.WIDTH(TRACE_ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (cap_d),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      emit_d = '0;
      if (state_q == S_EMIT) begin
         if (cur_q.mask[EV_INSTR])    emit_d[EV_INSTR] = 1'b1;
         else if (cur_q.mask[EV_REG]) emit_d[EV_REG]   = 1'b1;
         else                         emit_d[EV_MEM]   = cur_q.mask[EV_MEM];
      end
      rest_d = cur_q.mask & ~emit_d;
   end

   // Refill on the cycle the last pending bit goes out, so entries run back to back.
   assign pop = !empty && ((state_q == S_IDLE) || (rest_d == '0));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cur_q    <= '0;
         out_q    <= '0;
         mwrite_q <= 1'b0;
      end else begin
         out_q.mask <= emit_d;
         if (emit_d[EV_INSTR]) begin
            out_q.pc       <= cur_q.pc;
            out_q.instr    <= cur_q.instr;
            out_q.ra_raddr <= cur_q.ra_raddr;
            out_q.ra_rdata <= cur_q.ra_rdata;
            out_q.rb_raddr <= cur_q.rb_raddr;
            out_q.rb_rdata <= cur_q.rb_rdata;
         end
         if (emit_d[EV_REG]) begin
            out_q.rd_waddr <= cur_q.rd_waddr;
            out_q.rd_wdata <= cur_q.rd_wdata;
         end
         if (emit_d[EV_MEM]) begin
            out_q.maddr <= cur_q.maddr;
            out_q.mdata <= cur_q.mdata;
            out_q.mstrb <= cur_q.mstrb;
            mwrite_q    <= 1'b1;
         end
         if (pop) begin
            cur_q   <= head;
            state_q <= S_EMIT;
         end else begin
            cur_q.mask <= rest_d;
            if (rest_d == '0) state_q <= S_IDLE;
         end
      end
   end

   // A drop landing on the same edge as a clear counts as the first drop after it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (clr_ovf)               cnt_q <= CNT_W'(1);
         else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      end else if (clr_ovf) begin
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end
   end

   assign ovf        = ovf_q;
   assign drop_count = cnt_q;

   assign bfm_o.pc       = out_q.pc;
   assign bfm_o.instr    = out_q.instr;
   assign bfm_o.ivalid   = out_q.mask[EV_INSTR];
   assign bfm_o.ra_raddr = out_q.ra_raddr;
   assign bfm_o.ra_rdata = out_q.ra_rdata;
   assign bfm_o.rb_raddr = out_q.rb_raddr;
   assign bfm_o.rb_rdata = out_q.rb_rdata;
   assign bfm_o.rd_waddr = out_q.rd_waddr;
   assign bfm_o.rd_wdata = out_q.rd_wdata;
   assign bfm_o.rd_write = out_q.mask[EV_REG];
   assign bfm_o.maddr    = out_q.maddr;
   assign bfm_o.mdata    = out_q.mdata;
   assign bfm_o.mstrb    = out_q.mstrb;
   assign bfm_o.mwrite   = mwrite_q;
   assign bfm_o.mvalid   = out_q.mask[EV_MEM];

endmodule

// File: tb/tb_fwrisc_trace_serializer.sv
// Bench for fwrisc_trace_serializer: queue-based reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_fwrisc_trace_serializer;

   localparam int DEPTH = 8;
   localparam int CNT_W = 3;
   localparam logic [CNT_W-1:0] CMAX = '1;

   logic clock = 1'b0;
   logic reset;
   logic clr_ovf;
   logic ovf;
   logic [CNT_W-1:0] drop_count;

   fwrisc_trace_serializer_if tin();
   fwrisc_trace_serializer_if tout();

   fwrisc_trace_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .cap_i      (tin),
      .bfm_o      (tout),
      .clr_ovf    (clr_ovf),
      .ovf        (ovf),
      .drop_count (drop_count)
   );

   always #5 clock = ~clock;

   int ntot = 0;
   int npass = 0;

   task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
      ntot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else npass++;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [2:0]  m;
      logic [31:0] pc, instr;
      logic [5:0]  raa;
      logic [31:0] rad;
      logic [5:0]  rba;
      logic [31:0] rbd;
      logic [5:0]  rda;
      logic [31:0] rdd;
      logic [31:0] ma, md;
      logic [3:0]  ms;
   } ent_t;

   ent_t fq[$];
   ent_t cur;
   int   evs[$];
   logic [2:0]       e_stb = '0;
   logic [139:0]     e_ipl = '0;
   logic [37:0]      e_rpl = '0;
   logic [68:0]      e_mpl = '0;
   logic             e_ovf = 1'b0;
   logic [CNT_W-1:0] e_cnt = '0;

   task automatic model_reset();
      fq.delete();
      evs.delete();
      e_stb = '0; e_ipl = '0; e_rpl = '0; e_mpl = '0;
      e_ovf = 1'b0; e_cnt = '0;
   endtask

   task automatic model_step();
      ent_t e;
      bit popping, dropped;
      e_stb = '0;
      if (evs.size() > 0) begin
         int k;
         k = evs.pop_front();
         e_stb[k] = 1'b1;
         case (k)
            0:       e_ipl = {cur.pc, cur.instr, cur.raa, cur.rad, cur.rba, cur.rbd};
            1:       e_rpl = {cur.rda, cur.rdd};
            default: e_mpl = {cur.ma, cur.md, cur.ms, 1'b1};
         endcase
      end
      e.m   = {tin.mvalid & tin.mwrite, tin.rd_write, tin.ivalid};
      e.pc  = tin.pc;       e.instr = tin.instr;
      e.raa = tin.ra_raddr; e.rad   = tin.ra_rdata;
      e.rba = tin.rb_raddr; e.rbd   = tin.rb_rdata;
      e.rda = tin.rd_waddr; e.rdd   = tin.rd_wdata;
      e.ma  = tin.maddr;    e.md    = tin.mdata;   e.ms = tin.mstrb;
      popping = (evs.size() == 0) && (fq.size() > 0);
      dropped = (e.m != 0) && (fq.size() == DEPTH) && !popping;
      if (popping) begin
         cur = fq.pop_front();
         for (int b = 0; b < 3; b++) if (cur.m[b]) evs.push_back(b);
      end
      if (e.m != 0 && !dropped) fq.push_back(e);
      if (dropped) begin
         e_ovf = 1'b1;
         e_cnt = clr_ovf ? CNT_W'(1) : ((e_cnt == CMAX) ? CMAX : e_cnt + CNT_W'(1));
      end else if (clr_ovf) begin
         e_ovf = 1'b0;
         e_cnt = '0;
      end
   endtask

   always @(posedge clock or posedge reset) begin
      if (reset) model_reset();
      else       model_step();
   end

   // ---------------- per-cycle compare + strobe log ----------------
   int          slog[$];
   logic [31:0] plog[$];

   always @(negedge clock) begin
      chk("strobes", {tout.mvalid, tout.rd_write, tout.ivalid}, e_stb);
      chk("instr_payload", {tout.pc, tout.instr, tout.ra_raddr, tout.ra_rdata,
                            tout.rb_raddr, tout.rb_rdata}, e_ipl);
      chk("reg_payload", {tout.rd_waddr, tout.rd_wdata}, e_rpl);
      chk("mem_payload", {tout.maddr, tout.mdata, tout.mstrb, tout.mwrite}, e_mpl);
      chk("ovf_count", {ovf, drop_count}, {e_ovf, e_cnt});
      slog.push_back(int'({tout.mvalid, tout.rd_write, tout.ivalid}));
      if (tout.ivalid) plog.push_back(tout.pc);
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [2:0] stb();
      return {tout.mvalid, tout.rd_write, tout.ivalid};
   endfunction

   task automatic set_stb(bit iv, bit rw, bit mv, bit mw);
      tin.ivalid = iv; tin.rd_write = rw; tin.mvalid = mv; tin.mwrite = mw;
   endtask

   task automatic idle();
      set_stb(0, 0, 0, 0);
      clr_ovf = 1'b0;
   endtask

   task automatic set_rand_payload();
      tin.pc       = $urandom;        tin.instr    = $urandom;
      tin.ra_raddr = 6'($urandom);    tin.ra_rdata = $urandom;
      tin.rb_raddr = 6'($urandom);    tin.rb_rdata = $urandom;
      tin.rd_waddr = 6'($urandom);    tin.rd_wdata = $urandom;
      tin.maddr    = $urandom;        tin.mdata    = $urandom;
      tin.mstrb    = 4'($urandom);
   endtask

   task automatic nclk(int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic drain();
      int n = 0;
      idle();
      while ((fq.size() > 0 || evs.size() > 0) && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk("drain_bound", 256'(n < 200), 256'(1));
      nclk(3);
   endtask

   function automatic int nonzero_log();
      int nz = 0;
      foreach (slog[j]) if (slog[j] != 0) nz++;
      return nz;
   endfunction

   int first, run, tot;
   bit ordered;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle();
      set_rand_payload();
      nclk(2);
      chk("reset_strobes", stb(), 3'b000);
      chk("reset_payload", {tout.pc, tout.rd_wdata, tout.maddr, tout.mwrite}, '0);
      chk("reset_ovf", {ovf, drop_count}, '0);
      #2 reset = 1'b0;
      @(negedge clock);

      // 1: single retire
      tin.pc = 32'h100; tin.instr = 32'h13; set_stb(1, 0, 0, 0);
      @(negedge clock); idle();
      @(negedge clock); chk("t1_edge2_quiet", stb(), 3'b000);
      @(negedge clock); chk("t1_ivalid", stb(), 3'b001);
      chk("t1_pc_instr", {tout.pc, tout.instr}, {32'h100, 32'h13});
      @(negedge clock); chk("t1_one_cycle", stb(), 3'b000);

      // 2: triple collision
      drain();
      set_rand_payload();
      tin.rd_waddr = 6'd5; tin.rd_wdata = 32'hDEAD; tin.maddr = 32'h2000; tin.mstrb = 4'hF;
      set_stb(1, 1, 1, 1);
      @(negedge clock); idle();
      @(negedge clock);
      @(negedge clock); chk("t2_instr", stb(), 3'b001);
      @(negedge clock); chk("t2_reg", stb(), 3'b010);
      chk("t2_reg_data", {tout.rd_waddr, tout.rd_wdata}, {6'd5, 32'hDEAD});
      @(negedge clock); chk("t2_mem", stb(), 3'b100);
      chk("t2_mem_data", {tout.maddr, tout.mstrb, tout.mwrite}, {32'h2000, 4'hF, 1'b1});
      @(negedge clock); chk("t2_done", stb(), 3'b000);

      // 3: back-to-back retire+reg entries
      drain();
      slog.delete(); plog.delete();
      for (int i = 0; i < 4; i++) begin
         set_rand_payload();
         tin.pc = 32'h200 + 32'(4 * i);
         set_stb(1, 1, 0, 0);
         @(negedge clock);
      end
      idle();
      nclk(12);
      first = -1; run = 0; tot = nonzero_log();
      foreach (slog[j]) if (slog[j] != 0 && first < 0) first = j;
      if (first >= 0) for (int j = first; j < slog.size() && slog[j] != 0; j++) run++;
      chk("t3_run", 256'(run), 256'(8));
      chk("t3_total", 256'(tot), 256'(8));
      chk("t3_npc", 256'(plog.size()), 256'(4));
      if (plog.size() == 4)
         for (int j = 0; j < 4; j++) chk("t3_pc_seq", plog[j], 32'h200 + 32'(4 * j));

      // 4: overflow, saturation, clear-vs-drop
      drain();
      plog.delete();
      for (int i = 1; i <= 27; i++) begin
         if (i == 21) chk("t4_drops_after_20", {ovf, drop_count}, {1'b1, 3'd5});
         if (i == 27) chk("t4_saturated", {ovf, drop_count}, {1'b1, 3'd7});
         set_rand_payload();
         tin.pc = 32'(i);
         set_stb(1, 1, 1, 1);
         clr_ovf = (i == 27);
         @(negedge clock);
      end
      idle();
      chk("t4_drop_beats_clr", {ovf, drop_count}, {1'b1, 3'd1});
      drain();
      chk("t4_survivors", 256'(plog.size()), 256'(17));
      ordered = 1'b1;
      for (int j = 1; j < plog.size(); j++) if (plog[j] <= plog[j-1]) ordered = 1'b0;
      chk("t4_order", 256'(ordered), 256'(1));
      clr_ovf = 1'b1;
      @(negedge clock); clr_ovf = 1'b0;
      chk("t4_cleared", {ovf, drop_count}, '0);

      // 5: asynchronous reset mid-burst
      drain();
      for (int i = 0; i < 5; i++) begin
         set_rand_payload();
         set_stb(1, 1, 1, 1);
         @(negedge clock);
      end
      idle();
      nclk(2);
      #2 reset = 1'b1;
      #1;
      chk("t5_async_strobes", stb(), 3'b000);
      chk("t5_async_payload", {tout.pc, tout.rd_wdata, tout.maddr, tout.mwrite}, '0);
      chk("t5_async_ovf", {ovf, drop_count}, '0);
      @(negedge clock);
      #2 reset = 1'b0;
      slog.delete();
      nclk(8);
      chk("t5_quiet_after", 256'(nonzero_log()), 256'(0));

      // 6: unfiltered x0 write; memory read produces nothing
      set_rand_payload();
      tin.rd_waddr = 6'd0; tin.rd_wdata = 32'h55;
      set_stb(0, 1, 0, 0);
      @(negedge clock); idle();
      @(negedge clock);
      @(negedge clock);
      chk("t6_x0_write", {stb(), tout.rd_waddr, tout.rd_wdata}, {3'b010, 6'd0, 32'h55});
      drain();
      slog.delete();
      set_rand_payload();
      set_stb(0, 0, 1, 0);
      @(negedge clock); idle();
      nclk(5);
      chk("t6_read_dropped", 256'(nonzero_log()), 256'(0));

      // randomized traffic: heavy phase forces drops, light phase drains
      for (int i = 0; i < 400; i++) begin
         int p;
         p = (i < 200) ? 80 : 30;
         set_rand_payload();
         set_stb($urandom_range(99) < p, $urandom_range(99) < p,
                 $urandom_range(99) < p, $urandom_range(1) == 1);
         clr_ovf = ($urandom_range(29) == 0);
         @(negedge clock);
      end
      drain();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
